// File: rtl/sdatop_pkg.sv
// Shared definitions for the two-wire serial receiver.
// Holds the FSM encoding, default word width and line-event rules.
package sdatop_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_DATA = 3'b010,
        ST_WAIT = 3'b100
    } state_t;

    // START: sda falls while scl high
    function automatic logic ev_start(
        input logic scl_s,
        input logic sda_s,
        input logic sda_edge
    );
        return scl_s & sda_edge & ~sda_s;
    endfunction

    // STOP: sda rises while scl high
    function automatic logic ev_stop(
        input logic scl_s,
        input logic sda_s,
        input logic sda_edge
    );
        return scl_s & sda_edge & sda_s;
    endfunction

    // SAMPLE: scl rises
    function automatic logic ev_sample(
        input logic scl_s,
        input logic scl_edge
    );
        return scl_s & scl_edge;
    endfunction

endpackage

// File: rtl/sdatop_line_sync.sv
// Two-flop synchronizer plus history flop for one line.
// Ports: clk_i, rst_ni, line_i -> sync_o (synchronized), edge_o (changed).
module line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic sync_o,
    output logic edge_o
);

    logic s1_q;
    logic s2_q;
    logic h_q;

    // Idle line level is high, so all flops reset to 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            h_q  <= 1'b1;
        end else begin
            s1_q <= line_i;
            s2_q <= s1_q;
            h_q  <= s2_q;
        end
    end

    assign sync_o = s2_q;
    assign edge_o = s2_q ^ h_q;

endmodule

// File: rtl/sdatop.sv
// Two-wire serial receiver: frames WIDTH bits MSB-first between
// START/STOP and offers each word on a valid/ready port.
// Ports: sclk, rst (async, active-low), scl, sda, data, out_valid,
//        out_ready, frame_err (pulse), overrun (pulse).
module sdatop
    import sdatop_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             scl,
    input  logic             sda,
    output logic [WIDTH-1:0] data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    logic scl_s, scl_e, sda_s, sda_e;

    line_sync u_scl (
        .clk_i (sclk),
        .rst_ni(rst),
        .line_i(scl),
        .sync_o(scl_s),
        .edge_o(scl_e)
    );

    line_sync u_sda (
        .clk_i (sclk),
        .rst_ni(rst),
        .line_i(sda),
        .sync_o(sda_s),
        .edge_o(sda_e)
    );

    logic             start_q, stop_q, sample_q, bit_q;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             done;
    logic             load;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ferr_d  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            ST_DATA: begin
                if (stop_q) begin
                    ferr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (start_q) begin
                    ferr_d = 1'b1;
                    cnt_d  = '0;
                    sr_d   = '0;
                end else if (sample_q) begin
                    sr_d  = WIDTH'({sr_q, bit_q});
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(WIDTH)) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Extra scl rises (trailing bit) are ignored here.
                if (stop_q) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (start_q) begin
                    ferr_d  = 1'b1;
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A handshake in the completion cycle frees the slot for the new word.
    always_comb begin
        load    = done & (~valid_q | out_ready);
        ovr_d   = done & valid_q & ~out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = sr_q;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            sample_q <= 1'b0;
            bit_q    <= 1'b1;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sr_q     <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            start_q  <= ev_start(scl_s, sda_s, sda_e);
            stop_q   <= ev_stop(scl_s, sda_s, sda_e);
            sample_q <= ev_sample(scl_s, scl_e);
            bit_q    <= sda_s;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign data      = data_q;
    assign out_valid = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
